// File: rtl/move_scheduler_pkg.sv
// Shared types and helpers for the move scheduler: direction codes, FSM states,
// the one-entry request record and the lowest-index-wins direction encoder.
package move_scheduler_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    WAIT_FRAME
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } move_req_t;

  // Up beats down beats left beats right when several bits are set.
  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    if (v[0])      return DIR_UP;
    else if (v[1]) return DIR_DOWN;
    else if (v[2]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/move_req_slot.sv
// One-entry move request buffer; a new load overwrites the held request and
// beats a pop issued in the same cycle.
module move_req_slot
  import move_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] load_dir,
  input  logic       pop,
  output move_req_t  req
);

  always_ff @(posedge clk) begin
    if (!rst_n)    req       <= '0;
    else if (load) req       <= '{valid: 1'b1, dir: load_dir};
    else if (pop)  req.valid <= 1'b0;
  end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates button and debug move requests, issues them one at a time to the
// move engine, then aligns the grid commit to the frame tick with a holdoff.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_dir,
  input  logic [3:0] dbg_move,
  input  logic       lock,
  input  logic       frame_tick,
  input  logic       move_ready,
  input  logic       move_done,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       move_is_dbg,
  output logic       commit,
  output logic       busy,
  output logic       timeout_err
);

  localparam int HO_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  state_t           state, state_n;
  logic [3:0]       btn_prev;
  logic [3:0]       btn_rise;
  logic [HO_W-1:0]  holdoff;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cmd_dir;
  logic             cmd_dbg;
  logic             btn_load, dbg_load, btn_pop, dbg_pop;
  logic             commit_n, to_err;
  move_req_t        btn_req, dbg_req;

  assign btn_rise = btn_dir & ~btn_prev;
  assign btn_load = (|btn_rise) && !lock && (holdoff == '0);
  assign dbg_load = |dbg_move;

  move_req_slot u_btn_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (btn_load),
    .load_dir (prio_enc(btn_rise)),
    .pop      (btn_pop),
    .req      (btn_req)
  );

  move_req_slot u_dbg_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dbg_load),
    .load_dir (prio_enc(dbg_move)),
    .pop      (dbg_pop),
    .req      (dbg_req)
  );

  always_comb begin
    state_n  = state;
    dbg_pop  = 1'b0;
    btn_pop  = 1'b0;
    commit_n = 1'b0;
    to_err   = 1'b0;
    case (state)
      IDLE: begin
        if (dbg_req.valid) begin
          dbg_pop = 1'b1;
          state_n = ISSUE;
        end else if (btn_req.valid) begin
          btn_pop = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE:
        if (move_ready) state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (move_done) begin
          state_n = WAIT_FRAME;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          to_err  = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_FRAME: begin
        // A tick arriving together with move_done is ignored; only ticks seen here count.
        if (frame_tick) begin
          commit_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      btn_prev    <= '0;
      holdoff     <= '0;
      cnt         <= '0;
      cmd_dir     <= '0;
      cmd_dbg     <= 1'b0;
      commit      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_n;
      btn_prev <= btn_dir;
      commit   <= commit_n;
      cnt      <= (state == WAIT_DONE) ? cnt + 1'b1 : '0;
      if (to_err) timeout_err <= 1'b1;
      if (dbg_pop) begin
        cmd_dir <= dbg_req.dir;
        cmd_dbg <= 1'b1;
      end else if (btn_pop) begin
        cmd_dir <= btn_req.dir;
        cmd_dbg <= 1'b0;
      end
      // Debug moves commit without starting a holdoff window.
      if (commit_n && !cmd_dbg)              holdoff <= HO_W'(HOLDOFF_FRAMES);
      else if (frame_tick && holdoff != '0)  holdoff <= holdoff - 1'b1;
    end
  end

  assign move_valid  = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign move_dir    = cmd_dir;
  assign move_is_dbg = cmd_dbg;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus a randomized
// debug-request run checked against a command-sequence model.
module tb_move_scheduler;

  typedef struct packed {
    logic [1:0] dir;
    logic       dbg;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_dir, dbg_move;
  logic       lock, frame_tick, move_ready, move_done;
  logic       move_valid, move_is_dbg, commit, busy, timeout_err;
  logic [1:0] move_dir;

  int   checks = 0, errors = 0;
  int   ncommit = 0, nvalid = 0, fcnt = 0, done_cnt = 0;
  bit   eng_auto = 0, fr_auto = 0, rdy_rand = 0, btn_rand = 0;
  cmd_t obs[$];
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  move_scheduler #(.HOLDOFF_FRAMES(12), .TIMEOUT_CYCLES(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_dir(btn_dir), .dbg_move(dbg_move), .lock(lock),
    .frame_tick(frame_tick), .move_ready(move_ready), .move_done(move_done),
    .move_valid(move_valid), .move_dir(move_dir), .move_is_dbg(move_is_dbg),
    .commit(commit), .busy(busy), .timeout_err(timeout_err)
  );

  // Reference rule: lowest set bit names the direction.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd3;
  endfunction

  // Close the current cycle (record handshake/commit), advance one clock, drive background inputs.
  task automatic step();
    if (move_valid && move_ready) begin
      obs.push_back({move_dir, move_is_dbg});
      if (eng_auto) done_cnt = $urandom_range(1, 10);
    end
    if (commit) ncommit++;
    if (move_valid) nvalid++;
    @(posedge clk);
    #1;
    dbg_move = 4'b0; move_done = 1'b0; frame_tick = 1'b0;
    if (fr_auto) begin
      fcnt++;
      if (fcnt % 7 == 0) frame_tick = 1'b1;
    end
    if (eng_auto && done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) move_done = 1'b1;
    end
    if (rdy_rand) move_ready = 1'($urandom_range(0, 1));
    if (btn_rand) btn_dir = 4'($urandom);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      frame_tick = 1'b1;
    end
    step();
  endtask

  task automatic press(input logic [3:0] v);
    step();
    btn_dir = v;
    steps(2);
    btn_dir = 4'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (obs.size() < target && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (obs.size() < target) begin
      errors++;
      $display("FAIL wait_handshake: got %0d commands, expected %0d", obs.size(), target);
    end
  endtask

  task automatic wait_quiet();
    int q = 0, n = 0;
    while (q < 3 && n < 400) begin
      step();
      n++;
      if (!busy && !move_valid) q++;
      else q = 0;
    end
    checks++;
    if (q < 3) begin
      errors++;
      $display("FAIL wait_quiet: still busy after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    steps(3);
    checks++;
    if ({move_valid, move_dir, move_is_dbg, commit, busy, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {move_valid, move_dir, move_is_dbg, commit, busy, timeout_err});
    end
    rst_n = 1'b1;
    steps(2);
  endtask

  task automatic test_button_path();
    int c0 = ncommit;
    step();
    btn_dir = 4'b0100;
    step();
    checks++;
    if (move_valid !== 1'b0) begin
      errors++; $display("FAIL btn_lat1: move_valid got %b expected 0", move_valid);
    end
    step();
    checks++;
    if ({move_valid, move_dir, move_is_dbg} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("FAIL btn_issue: got v=%b d=%0d dbg=%b expected v=1 d=2 dbg=0",
                         move_valid, move_dir, move_is_dbg);
    end
    step();
    checks++;
    if ({move_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL btn_valid_drop: got v=%b busy=%b expected v=0 busy=1", move_valid, busy);
    end
    steps(4);
    move_done = 1'b1;
    steps(3);
    frame_tick = 1'b1;
    checks++;
    if (commit !== 1'b0) begin
      errors++; $display("FAIL btn_early_commit: got %b expected 0", commit);
    end
    step();
    checks++;
    if ({commit, busy} !== 2'b10) begin
      errors++; $display("FAIL btn_commit: got commit=%b busy=%b expected 1 0", commit, busy);
    end
    step();
    checks++;
    if (commit !== 1'b0 || ncommit - c0 !== 1) begin
      errors++; $display("FAIL btn_commit_once: got commit=%b count=%0d expected 0 1", commit, ncommit - c0);
    end
    btn_dir = 4'b0;
  endtask

  task automatic test_holdoff();
    int base = obs.size();
    int c0;
    ticks(3);
    press(4'b1000);
    steps(6);
    checks++;
    if (obs.size() !== base || busy !== 1'b0) begin
      errors++; $display("FAIL holdoff_3: got %0d cmds busy=%b expected %0d 0", obs.size(), busy, base);
    end
    ticks(8);
    press(4'b1000);
    steps(6);
    checks++;
    if (obs.size() !== base) begin
      errors++; $display("FAIL holdoff_11: got %0d cmds expected %0d", obs.size(), base);
    end
    ticks(1);
    press(4'b1000);
    steps(4);
    checks++;
    if (obs.size() !== base + 1 || obs[obs.size()-1] !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL holdoff_12: got %0d cmds last=%b expected %0d last=110",
                         obs.size(), obs[obs.size()-1], base + 1);
    end
    c0 = ncommit;
    move_done = 1'b1;
    steps(2);
    frame_tick = 1'b1;
    steps(2);
    checks++;
    if (ncommit - c0 !== 1) begin
      errors++; $display("FAIL holdoff_commit: got %0d commits expected 1", ncommit - c0);
    end
  endtask

  task automatic test_priority();
    int base;
    ticks(12);
    obs.delete();
    eng_auto = 1; fr_auto = 1;
    step();
    btn_dir  = 4'b0001;
    dbg_move = 4'b1000;
    steps(3);
    btn_dir = 4'b0;
    wait_quiet();
    checks++;
    if (obs.size() !== 2 || obs[0] !== {2'd3, 1'b1} || obs[1] !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL priority: got %0d cmds first=%b second=%b expected 2 111 000",
                         obs.size(), obs[0], obs[1]);
    end
    // Overwrite: two debug pulses while busy, only the later one survives.
    obs.delete();
    eng_auto = 0; done_cnt = 0;
    step();
    dbg_move = 4'b0001;
    wait_hs(1);
    dbg_move = 4'b0010;
    steps(2);
    dbg_move = 4'b0100;
    steps(2);
    move_done = 1'b1;
    eng_auto = 1;
    wait_quiet();
    base = obs.size();
    checks++;
    if (base !== 2 || obs[0] !== {2'd0, 1'b1} || obs[1] !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL overwrite: got %0d cmds first=%b second=%b expected 2 001 101",
                         base, obs[0], obs[1]);
    end
  endtask

  task automatic test_lock();
    int base, v0;
    eng_auto = 0; fr_auto = 0; done_cnt = 0;
    ticks(12);
    base = obs.size();
    v0 = nvalid;
    lock = 1'b1;
    press(4'b0010);
    steps(6);
    lock = 1'b0;
    steps(3);
    checks++;
    if (obs.size() !== base || nvalid !== v0 || busy !== 1'b0) begin
      errors++; $display("FAIL lock: got %0d valid cycles busy=%b expected 0 0", nvalid - v0, busy);
    end
  endtask

  task automatic test_backpressure();
    int base = obs.size();
    int n = 0;
    move_ready = 1'b0;
    eng_auto = 1; fr_auto = 1;
    step();
    dbg_move = 4'b1000;
    while (!move_valid && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({move_valid, move_dir, move_is_dbg} !== {1'b1, 2'd3, 1'b1}) begin
        errors++; $display("FAIL stall_stable: cycle %0d got v=%b d=%0d dbg=%b expected 1 3 1",
                           i, move_valid, move_dir, move_is_dbg);
      end
    end
    move_ready = 1'b1;
    step();
    checks++;
    if (move_valid !== 1'b0 || obs.size() !== base + 1 || obs[obs.size()-1] !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL stall_release: got v=%b cmds=%0d expected 0 %0d", move_valid, obs.size(), base + 1);
    end
    wait_quiet();
  endtask

  task automatic test_timeout();
    int base, c0;
    eng_auto = 0; fr_auto = 0; done_cnt = 0;
    move_ready = 1'b1;
    base = obs.size();
    step();
    dbg_move = 4'b0001;
    wait_hs(base + 1);
    steps(15);
    checks++;
    if ({busy, timeout_err} !== 2'b10) begin
      errors++; $display("FAIL timeout_early: got busy=%b err=%b expected 1 0", busy, timeout_err);
    end
    step();
    checks++;
    if ({busy, timeout_err} !== 2'b01) begin
      errors++; $display("FAIL timeout_set: got busy=%b err=%b expected 0 1", busy, timeout_err);
    end
    c0 = ncommit;
    ticks(2);
    checks++;
    if (ncommit !== c0 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_no_commit: got %0d commits err=%b expected 0 1", ncommit - c0, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int base = obs.size();
    int c0;
    step();
    dbg_move = 4'b0010;
    wait_hs(base + 1);
    move_done = 1'b1;
    steps(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({move_valid, move_dir, move_is_dbg, commit, busy, timeout_err} !== 7'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b expected 0000000",
                         {move_valid, move_dir, move_is_dbg, commit, busy, timeout_err});
    end
    c0 = ncommit;
    step();
    frame_tick = 1'b1;
    steps(3);
    checks++;
    if (ncommit !== c0 || busy !== 1'b0 || obs.size() !== base + 1) begin
      errors++; $display("FAIL rst_mid_no_commit: got commits=%0d busy=%b cmds=%0d expected 0 0 %0d",
                         ncommit - c0, busy, obs.size(), base + 1);
    end
  endtask

  task automatic test_random();
    int c0;
    logic [3:0] v, last;
    obs.delete();
    exp_q.delete();
    eng_auto = 1; fr_auto = 1; rdy_rand = 1;
    lock = 1'b1; btn_rand = 1;
    c0 = ncommit;
    for (int r = 0; r < 20; r++) begin
      wait_quiet();
      v = 4'($urandom_range(1, 15));
      dbg_move = v;
      exp_q.push_back({first_set(v), 1'b1});
      wait_hs(exp_q.size());
      last = 4'b0;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        steps($urandom_range(1, 2));
        if (!busy) break;
        v = 4'($urandom_range(1, 15));
        dbg_move = v;
        last = v;
      end
      if (last != 4'b0) exp_q.push_back({first_set(last), 1'b1});
    end
    wait_quiet();
    btn_rand = 0; btn_dir = 4'b0; lock = 1'b0; rdy_rand = 0; move_ready = 1'b1;
    checks++;
    if (obs.size() !== exp_q.size() || ncommit - c0 !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d cmds %0d commits expected %0d",
                         obs.size(), ncommit - c0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_cmd[%0d]: got %b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; btn_dir = 4'b0; dbg_move = 4'b0; lock = 1'b0;
    frame_tick = 1'b0; move_ready = 1'b1; move_done = 1'b0;
    test_reset();
    test_button_path();
    test_holdoff();
    test_priority();
    test_lock();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between the debounced direction buttons / debug controller and the game-logic move engine.
- Arbitrates move requests from two sources: player buttons and debug forced moves.
- Issues one move at a time over a valid/ready handshake and waits for completion.
- Aligns grid commit to the frame tick and enforces a post-move holdoff, so the new-tile animation is not interrupted.

Parameters:
- HOLDOFF_FRAMES, 12, frames after a commit during which button requests are ignored.
- TIMEOUT_CYCLES, 1024, maximum cycles WAIT_DONE may last before abort.
- CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- btn_dir  in  4  debounced button levels: [0]=up, [1]=down, [2]=left, [3]=right.
- dbg_move  in  4  debug forced-move pulses, same bit order, one cycle wide.
- lock  in  1  high while the welcome screen shows; blocks button requests only.
- frame_tick  in  1  one-cycle pulse on vsync rising edge.
- move_ready  in  1  move engine idle and able to accept a command.
- move_done  in  1  one-cycle pulse; move engine finished the current move.
- move_valid  out  1  command valid.
- move_dir  out  2  encoded direction: 0=up, 1=down, 2=left, 3=right.
- move_is_dbg  out  1  current command came from the debug source.
- commit  out  1  one-cycle pulse; grid may be latched for display.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on WAIT_DONE timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending slots empty, holdoff counter 0, btn_prev = 0.
- Button edge detection:
  - btn_rise = btn_dir & ~btn_prev, with btn_prev registered every cycle.
  - If several bits rise in the same cycle, take the lowest index (up > down > left > right).
- Button pending slot (1 entry, valid bit + 2-bit dir):
  - Loaded on btn_rise when lock=0 and the holdoff counter is 0.
  - If already full, the new request overwrites it (latest wins).
- Debug pending slot (1 entry):
  - Loaded on any dbg_move pulse, same priority encoding.
  - Ignores lock and holdoff; if full, the new pulse overwrites it.
- Arbitration: the debug slot always beats the button slot.
- State machine:
  - IDLE -> ISSUE when either slot is valid. The winning slot is popped into the command register the same cycle.
  - ISSUE: move_valid=1, move_dir/move_is_dbg held stable. Leaves to WAIT_DONE on the cycle move_valid && move_ready; move_valid drops the next cycle.
  - WAIT_DONE: timeout counter increments each cycle.
    - move_done -> WAIT_FRAME.
    - Counter reaching TIMEOUT_CYCLES-1 without move_done -> set timeout_err, return to IDLE, no commit.
  - WAIT_FRAME: on frame_tick, pulse commit for 1 cycle, load holdoff counter with HOLDOFF_FRAMES, go to IDLE.
    - If the command was debug, commit still pulses but the holdoff counter is not loaded.
- Holdoff counter: decrements by 1 on each frame_tick while nonzero; saturates at 0.
- Simultaneous events:
  - move_done and frame_tick in the same cycle: the commit waits for the next frame_tick. A tick only counts in WAIT_FRAME.
  - A slot load and a pop of the same slot in the same cycle: the load wins; the slot stays valid holding the new request.
- Latency:
  - Request edge to move_valid: 2 cycles (edge detect register + IDLE pop).
  - move_done to commit: at most one frame.
- Reset mid-operation clears everything, including an in-flight command. The move engine is reset by the same rst_n.

Decomposition:
- Shared package holds: direction encoding constants (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), the state enum (IDLE, ISSUE, WAIT_DONE, WAIT_FRAME), and the 4-to-2 priority-encode function.
- One sub-module: move_req_slot. It is the one-entry request buffer (load/pop/overwrite, valid + dir) and is instantiated twice, once for buttons and once for debug.

Test Plan:
- Button path: btn_dir goes 0000->0100 (left) with lock=0, move_ready=1.
  - Expect move_valid=1 with move_dir=2 two cycles later, held for 1 cycle.
  - move_done 5 cycles later, then frame_tick -> exactly one commit pulse; busy low after it.
- Holdoff: after a button commit with HOLDOFF_FRAMES=12, press right after 3 frame_ticks -> ignored. Press it again after 12 frame_ticks -> accepted with move_dir=3.
- Priority and overwrite:
  - btn up rise and dbg_move=1000 in the same cycle -> first command is dir=3 with move_is_dbg=1, the button up command follows.
  - Two dbg pulses (down, then left) while busy -> only left is issued afterwards.
- Lock and backpressure:
  - lock=1 with a button rise -> no move_valid.
  - move_ready=0 for 20 cycles -> move_valid and move_dir stay stable, handshake completes on the first ready cycle.
- Timeout and reset:
  - With TIMEOUT_CYCLES=16, withhold move_done -> timeout_err=1 after 16 cycles in WAIT_DONE, no commit, state IDLE.
  - rst_n=0 for 1 cycle mid-WAIT_FRAME -> all outputs 0 and no commit on the next frame_tick.
